// File: rtl/dpram_port_arbiter.sv
// Port-B arbiter and sequencer for the 4096 x 32 dual-port RAM.
// Two masters (m0 = DMA, m1 = debug/loader) share RAM port B under a
// round-robin grant. Each access runs IDLE -> ISSUE -> WAIT -> ACK, so one
// access completes at most every 4 cycles. Every output comes from a register.
//
// Handshake (req/ack): a master raises req with we/addr/wr_data already valid
// and holds all of them unchanged until it sees ack. ack is a one-cycle pulse,
// and rd_data is valid in that cycle. req may stay high through the ACK cycle
// with new fields to chain the next access. Requests are only sampled in IDLE.
module dpram_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rd_data,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   prio;       // master that wins a tie; always points away from the last served
  logic   sel;        // master being served by the current access
  logic   grant;
  logic   grant_sel;

  assign state_dbg = state;

  // Next-state logic and grant decision, with the round-robin tie-break.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          grant     = 1'b1;
          grant_sel = prio;
        end else if (m0_req) begin
          grant     = 1'b1;
          grant_sel = 1'b0;
        end else if (m1_req) begin
          grant     = 1'b1;
          grant_sel = 1'b1;
        end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // RAM port-B drive, read-data capture, ack pulses and the priority pointer.
  // Clearing ram_we asynchronously keeps a write from committing if reset
  // lands before the ISSUE closing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel        <= 1'b0;
      prio       <= 1'b0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_din    <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      m0_rd_data <= '0;
      m1_rd_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            sel      <= grant_sel;
            ram_addr <= grant_sel ? m1_addr    : m0_addr;
            ram_din  <= grant_sel ? m1_wr_data : m0_wr_data;
            ram_we   <= grant_sel ? m1_we      : m0_we;
          end
        end
        ISSUE: begin
          ram_we <= 1'b0;
        end
        WAIT: begin
          // For a write, the RAM's read port already shows the new word.
          if (sel) begin
            m1_rd_data <= ram_dout;
            m1_ack     <= 1'b1;
          end else begin
            m0_rd_data <= ram_dout;
            m0_ack     <= 1'b1;
          end
        end
        ACK: begin
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          prio   <= ~sel;
        end
        default: ;
      endcase
    end
  end

  // busy follows the state one-for-one and is registered like every other output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= 1'b0;
    else       busy <= (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: behavioural dual-port RAM, a transaction-level
// reference model (one access in flight, round-robin grants, fixed latency),
// directed scenarios and a randomized two-master phase.
module tb_dpram_port_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b0;

  // ---------------- DUT signals ----------------
  logic [1:0]         req = '0;
  logic [1:0]         we = '0;
  logic [1:0][AW-1:0] addr = '0;
  logic [1:0][DW-1:0] wdata = '0;
  logic               m0_ack, m1_ack;
  logic [DW-1:0]      m0_rd, m1_rd;
  logic [AW-1:0]      ram_addr;
  logic               ram_we;
  logic [DW-1:0]      ram_din;
  logic [DW-1:0]      ram_dout;
  logic               busy;
  logic [1:0]         state_dbg;
  wire  [1:0]         ack = {m1_ack, m0_ack};
  wire  [1:0][DW-1:0] rd_d = {m1_rd, m0_rd};

  // CPU port A of the RAM
  logic          wea = 1'b0;
  logic [AW-1:0] addra = '0;
  logic [DW-1:0] dina = '0;

  dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wr_data(wdata[0]),
    .m0_ack(m0_ack), .m0_rd_data(m0_rd),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wr_data(wdata[1]),
    .m1_ack(m1_ack), .m1_rd_data(m1_rd),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy), .state_dbg(state_dbg)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  // ---------------- RAM model (write-first, port A then port B) ----------------
  logic [DW-1:0] mem [4096];
  always @(posedge clk) begin
    if (wea) mem[addra] = dina;
    if (ram_we) mem[ram_addr] = ram_din;
    ram_dout <= mem[ram_addr];
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One access at a time: accepted when free, RAM operation one edge later,
  // ack visible for one cycle two edges after acceptance, free again after three.
  logic [DW-1:0] ref_mem [4096];
  int            m_left = 0;
  logic          m_g = 1'b0;
  logic          m_prio = 1'b0;
  logic          t_we = 1'b0;
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_data = '0;
  logic [DW-1:0] m_result = '0;
  logic [1:0]    exp_ack = '0;
  logic [1:0][DW-1:0] exp_rd = '0;
  logic          exp_busy = 1'b0;
  logic          exp_we = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_din = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_left = 0; m_prio = 1'b0; exp_ack = '0; exp_rd = '0;
      exp_busy = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
    end else begin
      if (wea) ref_mem[addra] = dina;
      exp_ack = '0;
      if (m_left == 3) begin
        if (t_we) ref_mem[t_addr] = t_data;
        m_result = ref_mem[t_addr];
        exp_we = 1'b0;
      end
      if (m_left == 2) begin
        exp_ack[m_g] = 1'b1;
        exp_rd[m_g] = m_result;
      end
      if (m_left > 0) m_left--;
      else if (req != 2'b00) begin
        m_g = (req == 2'b11) ? m_prio : req[1];
        t_we = we[m_g]; t_addr = addr[m_g]; t_data = wdata[m_g];
        exp_we = t_we; exp_addr = t_addr; exp_din = t_data;
        m_prio = ~m_g;
        m_left = 3;
      end
      exp_busy = (m_left > 0);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit            mon_en = 1'b0;
  int            we_pulses = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [1:0]    ack_log[$];
  logic [1:0]    exp_q[$];

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m0_ack", m0_ack, exp_ack[0]);
      chk("m1_ack", m1_ack, exp_ack[1]);
      chk("m0_rd_data", m0_rd, exp_rd[0]);
      chk("m1_rd_data", m1_rd, exp_rd[1]);
      chk("busy", busy, exp_busy);
      chk("ram_we", ram_we, exp_we);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_din", ram_din, exp_din);
      if (ram_we) begin we_pulses++; last_we_addr = ram_addr; end
      if (m0_ack) ack_log.push_back(2'd0);
      if (m1_ack) ack_log.push_back(2'd1);
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge. Raises the request and waits (bounded) for the ack.
  task automatic access(input int m, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit keep,
                        output logic [DW-1:0] rdv, output int lat);
    bit got = 1'b0;
    req[m] = 1'b1; we[m] = w; addr[m] = a; wdata[m] = d;
    lat = 0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (ack[m]) got = 1'b1;
    end
    if (!got) chk($sformatf("ack_timeout_m%0d", m), 32'd0, 32'd1);
    rdv = rd_d[m];
    if (!keep) begin req[m] = 1'b0; we[m] = 1'b0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    req = '0; we = '0; wea = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_master(input int m);
    logic [DW-1:0] rdv;
    int lat;
    repeat (25) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      access(m, 1'($urandom_range(0, 1)), 12'h100 + 12'($urandom_range(0, 15)),
             $urandom, 1'b0, rdv, lat);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] rdv, rdv1, rdv2, rdv3;
    int lat, lat1, lat2, lat3, p0;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    mem[12'h005] = 32'hDEADBEEF;
    ref_mem[12'h005] = 32'hDEADBEEF;

    #1 reset = 1'b1;
    #1 mon_en = 1'b1;
    // reset state
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_rd_data", m1_rd, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single read by m0
    p0 = we_pulses; ack_log.delete();
    access(0, 1'b0, 12'h005, 32'h0, 1'b0, rdv, lat);
    chk("single_read_data", rdv, 32'hDEADBEEF);
    chk("single_read_latency", lat, 3);
    repeat (3) @(negedge clk);
    chk("single_read_no_we", we_pulses - p0, 0);
    chk("single_read_ack_count", ack_log.size(), 1);

    // write then read by m1
    p0 = we_pulses;
    access(1, 1'b1, 12'h0FF, 32'h12345678, 1'b0, rdv, lat);
    chk("write_ack_data", rdv, 32'h12345678);
    repeat (2) @(negedge clk);
    chk("write_one_we_pulse", we_pulses - p0, 1);
    chk("write_we_addr", last_we_addr, 12'h0FF);
    access(1, 1'b0, 12'h0FF, 32'h0, 1'b0, rdv, lat);
    chk("readback_data", rdv, 32'h12345678);
    repeat (2) @(negedge clk);
    chk("readback_no_we", we_pulses - p0, 1);

    // back-to-back same master, fields changed in the ACK cycle
    ack_log.delete();
    access(0, 1'b0, 12'h010, 32'h0, 1'b1, rdv, lat);
    access(0, 1'b0, 12'h011, 32'h0, 1'b0, rdv1, lat1);
    chk("b2b_first", rdv, init_word(12'h010));
    chk("b2b_second", rdv1, init_word(12'h011));
    chk("b2b_second_latency", lat1, 4);
    repeat (3) @(negedge clk);
    chk("b2b_acks", ack_log.size(), 2);
    chk("b2b_no_m1", (ack_log.size() == 2) ? {30'd0, ack_log[0] | ack_log[1]} : 32'hFFFFFFFF, 0);

    // port-A write forwarded to a port-B read of the same address
    fork
      access(1, 1'b0, 12'h030, 32'h0, 1'b0, rdv, lat);
      begin
        @(negedge clk);
        wea = 1'b1; addra = 12'h030; dina = 32'hCAFEF00D;
        @(negedge clk);
        wea = 1'b0;
      end
    join
    chk("porta_forward", rdv, 32'hCAFEF00D);
    repeat (3) @(negedge clk);

    // reset during ISSUE of a write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h020; wdata[0] = 32'hAAAA5555;
    @(posedge clk);
    #2;
    chk("pre_reset_ram_we", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("midrst_ram_we", ram_we, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    chk("midrst_ram_din", ram_din, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_m1_rd_data", m1_rd, 0);
    req = '0; we = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // simultaneous continuous requests straight after reset: m0, m1, m0, m1
    ack_log.delete();
    exp_q = '{2'd0, 2'd1, 2'd0, 2'd1};
    fork
      begin
        access(0, 1'b0, 12'h020, 32'h0, 1'b1, rdv, lat);
        access(0, 1'b0, 12'h021, 32'h0, 1'b0, rdv1, lat1);
      end
      begin
        access(1, 1'b0, 12'h0FF, 32'h0, 1'b1, rdv2, lat2);
        access(1, 1'b0, 12'h031, 32'h0, 1'b0, rdv3, lat3);
      end
    join
    chk("reset_write_dropped", rdv, init_word(12'h020));
    chk("rr_m0_second", rdv1, init_word(12'h021));
    chk("rr_m1_first", rdv2, 32'h12345678);
    chk("rr_m1_second", rdv3, init_word(12'h031));
    chk("rr_m1_wait", lat2, 7);
    repeat (3) @(negedge clk);
    chk("rr_ack_count", ack_log.size(), exp_q.size());
    while (exp_q.size() > 0 && ack_log.size() > 0)
      chk("rr_order", ack_log.pop_front(), exp_q.pop_front());

    // randomized two-master traffic with random port-A writes
    fork
      rand_master(0);
      rand_master(1);
      begin
        repeat (250) begin
          @(negedge clk);
          if ($urandom_range(0, 3) == 0) begin
            wea = 1'b1; addra = 12'h100 + 12'($urandom_range(0, 15)); dina = $urandom;
          end else begin
            wea = 1'b0;
          end
        end
        wea = 1'b0;
      end
    join
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

endmodule
